// File: rtl/dcache_miss_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_miss_ctrl_pkg
// Description : Shared types and constants for the data-cache miss sequencer.
//               Holds the sequencer state encoding, default geometry and
//               helpers that derive address field widths from the geometry.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_miss_ctrl_pkg;

    // Sequencer states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_REFILL = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int C_DEF_MEM_LAT    = 4;
    localparam int C_DEF_LINE_WORDS = 4;
    localparam int C_DEF_INDEX_W    = 3;

    // Lowest address bit of the set index: word offset bits plus byte offset.
    function automatic int index_lsb(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    // Tag covers everything above the index field of a 32-bit byte address.
    function automatic int tag_width(input int index_w, input int line_words);
        return 32 - index_w - index_lsb(line_words);
    endfunction

endpackage : dcache_miss_ctrl_pkg
`default_nettype wire

// File: rtl/dcache_miss_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_miss_ctrl_if
// Description : Bundle between the miss sequencer, the MEM-stage pipeline,
//               the cache array and the data-memory port.
//               master : the miss sequencer (drives stall / memory / array
//                        control, samples request and array status)
//               slave  : pipeline + array + memory side
// Signals     : req, req_we, req_addr      MEM-stage access
//               hit, victim_dirty/tag/word  array status for indexed line
//               mem_rdata                   data memory read data
//               stall                       pipeline freeze
//               mem_req/we/addr/wdata       data memory port
//               word_idx, fill_we, tag_we, dirty_set   array control
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_miss_ctrl_if #(
    parameter int WORD_W = 2,
    parameter int TAG_W  = 25
);
    logic              req;
    logic              req_we;
    logic [31:0]       req_addr;
    logic              hit;
    logic              victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic [31:0]       victim_word;
    logic [31:0]       mem_rdata;

    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [WORD_W-1:0] word_idx;
    logic              fill_we;
    logic              tag_we;
    logic              dirty_set;

    modport master (
        input  req, req_we, req_addr, hit, victim_dirty, victim_tag,
               victim_word, mem_rdata,
        output stall, mem_req, mem_we, mem_addr, mem_wdata, word_idx,
               fill_we, tag_we, dirty_set
    );

    modport slave (
        output req, req_we, req_addr, hit, victim_dirty, victim_tag,
               victim_word, mem_rdata,
        input  stall, mem_req, mem_we, mem_addr, mem_wdata, word_idx,
               fill_we, tag_we, dirty_set
    );
endinterface : dcache_miss_ctrl_if
`default_nettype wire

// File: rtl/dcache_miss_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : dcache_miss_ctrl_timer
// Description : Memory word timer. Counts MEM_LAT cycles per word and steps
//               the word index through the line. Both counters return to 0
//               after the last cycle of the last word, so the same timer
//               serves write-back and refill back to back.
// Ports       : i_clk, i_rst_n   clock, async active-low reset
//               i_en             a word transfer phase is active
//               o_word_idx       word within the line
//               o_last_cycle     final latency cycle of the current word
//               o_last_word      current word is the last of the line
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_miss_ctrl_timer #(
    parameter int MEM_LAT    = 4,
    parameter int LINE_WORDS = 4,
    parameter int WORD_W     = $clog2(LINE_WORDS)
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    input  wire logic              i_en,
    output logic [WORD_W-1:0]      o_word_idx,
    output logic                   o_last_cycle,
    output logic                   o_last_word
);

    // A single-cycle latency still needs a 1-bit counter to stay legal.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [CNT_W-1:0]  r_cyc;
    logic [WORD_W-1:0] r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc  <= '0;
            r_word <= '0;
        end else if (i_en) begin
            if (o_last_cycle) begin
                r_cyc  <= '0;
                r_word <= o_last_word ? '0 : r_word + WORD_W'(1);
            end else begin
                r_cyc  <= r_cyc + CNT_W'(1);
            end
        end
    end

    assign o_last_cycle = (r_cyc == CNT_W'(MEM_LAT - 1));
    assign o_last_word  = (r_word == WORD_W'(LINE_WORDS - 1));
    assign o_word_idx   = r_word;

endmodule : dcache_miss_ctrl_timer
`default_nettype wire

// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_miss_ctrl
// Description : Miss sequencer for a direct-mapped, write-back,
//               write-allocate data cache. On a miss it stalls the pipeline,
//               writes back a dirty victim word by word, refills the line in
//               order 0..LINE_WORDS-1, writes tag/valid, then releases the
//               stall so the replayed access hits.
// Ports       : i_clk     clock, all state on rising edge
//               i_rst_n   asynchronous active-low reset
//               bus       dcache_miss_ctrl_if.master (request, array status,
//                         memory port, array control, stall)
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_miss_ctrl
    import dcache_miss_ctrl_pkg::*;
#(
    parameter int MEM_LAT    = C_DEF_MEM_LAT,
    parameter int LINE_WORDS = C_DEF_LINE_WORDS,
    parameter int INDEX_W    = C_DEF_INDEX_W,
    parameter int TAG_W      = tag_width(INDEX_W, LINE_WORDS)
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    dcache_miss_ctrl_if.master bus
);

    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int IDX_LSB = index_lsb(LINE_WORDS);

    state_t             r_state;
    state_t             w_next;

    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_index;
    logic [TAG_W-1:0]   r_victim_tag;

    logic [WORD_W-1:0]  w_word_idx;
    logic               w_last_cycle;
    logic               w_last_word;
    logic               w_timer_en;
    logic               w_phase_end;
    logic               w_miss;
    logic               w_unused_bits;

    // Byte/word offset of the request and the memory read data are not
    // needed here: the array takes read data directly under fill_we.
    assign w_unused_bits = ^{bus.req_addr[IDX_LSB-1:0], bus.mem_rdata};

    assign w_miss      = bus.req & ~bus.hit;
    assign w_timer_en  = (r_state == ST_WB) || (r_state == ST_REFILL);
    assign w_phase_end = w_last_cycle & w_last_word;

    dcache_miss_ctrl_timer #(
        .MEM_LAT    (MEM_LAT),
        .LINE_WORDS (LINE_WORDS),
        .WORD_W     (WORD_W)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (w_timer_en),
        .o_word_idx   (w_word_idx),
        .o_last_cycle (w_last_cycle),
        .o_last_word  (w_last_word)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Miss address and victim tag are frozen at miss detection so later
    // pipeline activity on the request lines cannot disturb the sequence.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag        <= '0;
            r_index      <= '0;
            r_victim_tag <= '0;
        end else if ((r_state == ST_IDLE) && w_miss) begin
            r_tag        <= bus.req_addr[31 -: TAG_W];
            r_index      <= bus.req_addr[IDX_LSB +: INDEX_W];
            r_victim_tag <= bus.victim_tag;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_next = bus.victim_dirty ? ST_WB : ST_REFILL;
                end
            end
            ST_WB: begin
                if (w_phase_end) begin
                    w_next = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (w_phase_end) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.stall     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.word_idx  = w_word_idx;
        bus.fill_we   = 1'b0;
        bus.tag_we    = 1'b0;
        bus.dirty_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Reset already forces IDLE; the reset term keeps the two
                // request-driven outputs low while reset is held as well.
                bus.stall     = w_miss & i_rst_n;
                bus.dirty_set = bus.req & bus.req_we & bus.hit & i_rst_n;
            end
            ST_WB: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {r_victim_tag, r_index, w_word_idx, 2'b00};
                bus.mem_wdata = bus.victim_word;
            end
            ST_REFILL: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_addr  = {r_tag, r_index, w_word_idx, 2'b00};
                // Memory data is valid only on the last latency cycle.
                bus.fill_we   = w_last_cycle;
            end
            ST_DONE: begin
                bus.stall     = 1'b1;
                bus.tag_we    = 1'b1;
            end
            default: begin
                bus.stall     = 1'b0;
            end
        endcase
    end

endmodule : dcache_miss_ctrl
`default_nettype wire
